// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on the raw RX line and
// derives the oversampling factor for the variable-oversampling receiver.
// The line forwarded to the receiver is held idle until a factor is locked.
module uart_autobaud #(
  parameter int ow = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in,
  input  logic          relock,
  output logic [ow-1:0] o,
  output logic          rx_in,
  output logic          locked,
  output logic          err
);

  localparam int cw = ow + 4;

  localparam logic [cw-1:0] C_ONE  = {{(cw-1){1'b0}}, 1'b1};
  localparam logic [cw-1:0] C_ZERO = {cw{1'b0}};
  localparam logic [cw:0]   C_RND  = (cw+1)'(32'd4);
  localparam logic [ow+1:0] Q_MIN  = (ow+2)'(32'd4);
  localparam logic [ow+1:0] Q_MAX  = (ow+2)'((32'd1 << ow) - 32'd1);
  localparam logic [ow-1:0] O_RST  = ow'(32'd4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    CHECK   = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  state_t        state_r;
  logic          s1_r;
  logic          s_r;
  logic          sp_r;
  logic [1:0]    fill_r;   // synchronizer holds real line samples once fill_r[1] is set
  logic [cw-1:0] n_r;
  logic [cw-1:0] run_r;
  logic [cw-1:0] r0_r;
  logic [cw-1:0] nlat_r;
  logic [2:0]    fe_r;
  logic          pass_r;   // line seen high after lock; the tail of the sync byte is hidden

  logic          fall_s;
  logic          edge_s;
  logic [cw:0]   r0_lo_s;
  logic [cw:0]   r0_hi_s;
  logic          run_bad_s;
  logic          sat_s;
  logic [cw:0]   sum_s;
  logic [ow+1:0] q_s;
  logic          q_ok_s;

  // Edge detection, run-length tolerance window and rounded factor.
  always_comb begin
    fall_s    = sp_r & ~s_r;
    edge_s    = sp_r ^ s_r;
    r0_lo_s   = {2'b00, r0_r[cw-1:1]};
    r0_hi_s   = {r0_r, 1'b0};
    run_bad_s = ({1'b0, run_r} < r0_lo_s) || ({1'b0, run_r} > r0_hi_s);
    sat_s     = (&n_r) | (&run_r);
    sum_s     = {1'b0, nlat_r} + C_RND;
    q_s       = sum_s[cw:3];
    q_ok_s    = (q_s >= Q_MIN) && (q_s <= Q_MAX);
  end

  // Synchronizer, measurement FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      s1_r    <= 1'b1;
      s_r     <= 1'b1;
      sp_r    <= 1'b1;
      fill_r  <= 2'b00;
      n_r     <= C_ZERO;
      run_r   <= C_ZERO;
      r0_r    <= C_ZERO;
      nlat_r  <= C_ZERO;
      fe_r    <= 3'd0;
      pass_r  <= 1'b0;
      o       <= O_RST;
      rx_in   <= 1'b1;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      s1_r   <= in;
      s_r    <= s1_r;
      sp_r   <= s_r;
      fill_r <= {fill_r[0], 1'b1};
      err    <= 1'b0;
      if (relock) begin
        state_r <= IDLE;
        locked  <= 1'b0;
        rx_in   <= 1'b1;
        pass_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            // The reset value of the synchronizer is not a line sample.
            if (fill_r[1] && s_r) begin
              state_r <= ARM;
            end
          end
          ARM: begin
            if (fall_s) begin
              n_r     <= C_ONE;
              run_r   <= C_ONE;
              fe_r    <= 3'd1;
              r0_r    <= C_ZERO;
              state_r <= MEASURE;
            end
          end
          MEASURE: begin
            n_r   <= n_r + C_ONE;
            run_r <= run_r + C_ONE;
            if (sat_s) begin
              err     <= 1'b1;
              state_r <= IDLE;
            end else if (edge_s) begin
              run_r <= C_ONE;
              if (r0_r == C_ZERO) begin
                r0_r <= run_r;
              end else if (run_bad_s) begin
                err     <= 1'b1;
                state_r <= IDLE;
              end else if (fall_s) begin
                fe_r <= fe_r + 3'd1;
                if (fe_r == 3'd4) begin
                  nlat_r  <= n_r;
                  state_r <= CHECK;
                end
              end
            end
          end
          CHECK: begin
            if (q_ok_s) begin
              o       <= q_s[ow-1:0];
              locked  <= 1'b1;
              pass_r  <= 1'b0;
              state_r <= LOCKED;
            end else begin
              err     <= 1'b1;
              state_r <= IDLE;
            end
          end
          LOCKED: begin
            rx_in  <= s_r | ~pass_r;
            pass_r <= pass_r | s_r;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
